// File: rtl/reram_sched_pkg.sv
// -----------------------------------------------------------------------------
// reram_sched_pkg
// Shared types for the ReRAM request scheduler: the FSM state encoding, the
// default write-buffer depth of the ReRAM model, and the requester index type.
// -----------------------------------------------------------------------------
package reram_sched_pkg;

  // Default number of unread writes the ReRAM model can hold.
  localparam int DEPTH_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } sched_state_e;

  // Requester index: 0 = port 0, 1 = port 1.
  typedef logic port_idx_t;

endpackage

// File: rtl/reram_rr_arbiter.sv
// -----------------------------------------------------------------------------
// reram_rr_arbiter
// Two-way round-robin grant. The pointer names the port that has priority this
// round; if that port is idle, the other port may take the grant.
//
// Ports:
//   req_i [1:0]  request per port
//   ptr_i        priority port index
//   gnt_o [1:0]  one-hot grant (all zero when no request)
// -----------------------------------------------------------------------------
module reram_rr_arbiter
  import reram_sched_pkg::*;
(
  input  logic [1:0] req_i,
  input  port_idx_t  ptr_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (req_i[ptr_i]) begin
      gnt_o[ptr_i] = 1'b1;
    end else if (req_i[~ptr_i]) begin
      gnt_o[~ptr_i] = 1'b1;
    end
  end

endmodule

// File: rtl/reram_req_sched.sv
// -----------------------------------------------------------------------------
// reram_req_sched
// Serialises transactions from two requesters onto a single ReRAM model port.
// One transaction is in flight at a time; EN is held with stable R_WB and
// mem_dat_o until the model answers with func_ack. An occupancy counter tracks
// unread writes so that writes into a full model and reads from an empty one
// are rejected without touching the model.
//
// Optional build macro:
//   RERAM_SCHED_TIMEOUT_EN  abandon a transaction after TIMEOUT_CYC cycles of
//                           EN without func_ack (error pulse to requester).
//
// State table:
//   ST_IDLE | waiting for a request; arbitrate, check occupancy, issue or reject
//   ST_BUSY | EN asserted, waiting for func_ack (or timeout when enabled)
//   ST_RESP | ack/err pulse visible to the granted port; flip priority pointer
//
// Ports:
//   wb_clk_i, wb_rst_i           clock, async active-low reset
//   req*_i, we*_i, dat*_i        requester n request, 1=write, write word
//                                (addr [29:20], data [7:0])
//   ack*_o, err*_o               one-cycle completion / rejection pulses
//   rdat_o                       read data, valid with the ack of a read
//   EN, R_WB, mem_dat_o          ReRAM model drive (R_WB=1 means read)
//   read_data, func_ack          ReRAM model response
// -----------------------------------------------------------------------------
module reram_req_sched
  import reram_sched_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64,
  parameter int DEPTH       = DEPTH_DEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        req0_i,
  input  logic        req1_i,
  input  logic        we0_i,
  input  logic        we1_i,
  input  logic [31:0] dat0_i,
  input  logic [31:0] dat1_i,
  output logic        ack0_o,
  output logic        ack1_o,
  output logic        err0_o,
  output logic        err1_o,
  output logic [31:0] rdat_o,
  output logic        EN,
  output logic        R_WB,
  output logic [31:0] mem_dat_o,
  input  logic [31:0] read_data,
  input  logic        func_ack
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  if (DEPTH < 1 || TIMEOUT_CYC < 1) begin : g_param_chk
    $error("reram_req_sched: DEPTH and TIMEOUT_CYC must be at least 1");
  end

  sched_state_e      state_q;
  port_idx_t         ptr_q;
  port_idx_t         gnt_idx_q;
  logic              we_q;
  logic              en_q;
  logic              r_wb_q;
  logic [31:0]       mem_dat_q;
  logic [31:0]       rdat_q;
  logic [1:0]        ack_q;
  logic [1:0]        err_q;
  logic [OCC_W-1:0]  occ_q;

`ifdef RERAM_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0]   to_q;
`endif

  logic [1:0]  gnt;
  port_idx_t   gnt_idx;
  logic        sel_we;
  logic [31:0] sel_dat;
  logic        reject;
  logic        req_live;

  reram_rr_arbiter u_arb (
    .req_i ({req1_i, req0_i}),
    .ptr_i (ptr_q),
    .gnt_o (gnt)
  );

  assign gnt_idx = port_idx_t'(gnt[1]);
  assign sel_we  = gnt_idx ? we1_i  : we0_i;
  assign sel_dat = gnt_idx ? dat1_i : dat0_i;
  // Only one transaction is ever outstanding, so occupancy seen in IDLE is exact.
  assign reject  = sel_we ? (occ_q == OCC_W'(DEPTH)) : (occ_q == '0);
  // A requester that dropped its request mid-transaction gets no pulse.
  assign req_live = gnt_idx_q ? req1_i : req0_i;

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q   <= ST_IDLE;
      ptr_q     <= 1'b0;
      gnt_idx_q <= 1'b0;
      we_q      <= 1'b0;
      en_q      <= 1'b0;
      r_wb_q    <= 1'b0;
      mem_dat_q <= '0;
      rdat_q    <= '0;
      ack_q     <= 2'b00;
      err_q     <= 2'b00;
      occ_q     <= '0;
`ifdef RERAM_SCHED_TIMEOUT_EN
      to_q      <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          ack_q <= 2'b00;
          err_q <= 2'b00;
          if (|gnt) begin
            gnt_idx_q <= gnt_idx;
            we_q      <= sel_we;
            if (reject) begin
              err_q[gnt_idx] <= 1'b1;
              state_q        <= ST_RESP;
            end else begin
              en_q      <= 1'b1;
              r_wb_q    <= ~sel_we;
              mem_dat_q <= sel_dat;
              state_q   <= ST_BUSY;
`ifdef RERAM_SCHED_TIMEOUT_EN
              to_q      <= '0;
`endif
            end
          end
        end

        ST_BUSY: begin
          if (func_ack) begin
            en_q <= 1'b0;
            // The model has consumed the access whether or not the requester
            // still waits, so occupancy always follows the completed access.
            if (we_q) begin
              occ_q <= occ_q + 1'b1;
            end else begin
              occ_q  <= occ_q - 1'b1;
              rdat_q <= read_data;
            end
            if (req_live) begin
              ack_q[gnt_idx_q] <= 1'b1;
            end
            state_q <= ST_RESP;
          end
`ifdef RERAM_SCHED_TIMEOUT_EN
          else if (to_q == TO_W'(TIMEOUT_CYC - 1)) begin
            en_q <= 1'b0;
            if (req_live) begin
              err_q[gnt_idx_q] <= 1'b1;
            end
            state_q <= ST_RESP;
          end else begin
            to_q <= to_q + 1'b1;
          end
`endif
        end

        ST_RESP: begin
          ack_q   <= 2'b00;
          err_q   <= 2'b00;
          ptr_q   <= ~gnt_idx_q;
          state_q <= ST_IDLE;
        end

        default: begin
          ack_q   <= 2'b00;
          err_q   <= 2'b00;
          en_q    <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ack0_o    = ack_q[0];
  assign ack1_o    = ack_q[1];
  assign err0_o    = err_q[0];
  assign err1_o    = err_q[1];
  assign rdat_o    = rdat_q;
  assign EN        = en_q;
  assign R_WB      = r_wb_q;
  assign mem_dat_o = mem_dat_q;

endmodule

// File: tb/tb_reram_req_sched.sv
// -----------------------------------------------------------------------------
// tb_reram_req_sched
// Directed bench for reram_req_sched with a small behavioural ReRAM model:
// writes answer in the first EN cycle, reads after 44 further cycles, memory
// indexed by word bits [29:20] and storing bits [7:0].
// -----------------------------------------------------------------------------
module tb_reram_req_sched;

  logic        clk;
  logic        rst_n;
  logic        req0, req1, we0, we1;
  logic [31:0] dat0, dat1;
  logic        ack0_o, ack1_o, err0_o, err1_o;
  logic [31:0] rdat_o;
  logic        EN, R_WB;
  logic [31:0] mem_dat_o;
  logic [31:0] read_data;
  logic        func_ack;

  int n_vec = 0;
  int n_bad = 0;

  reram_req_sched #(.TIMEOUT_CYC(64), .DEPTH(32)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst_n),
    .req0_i    (req0),
    .req1_i    (req1),
    .we0_i     (we0),
    .we1_i     (we1),
    .dat0_i    (dat0),
    .dat1_i    (dat1),
    .ack0_o    (ack0_o),
    .ack1_o    (ack1_o),
    .err0_o    (err0_o),
    .err1_o    (err1_o),
    .rdat_o    (rdat_o),
    .EN        (EN),
    .R_WB      (R_WB),
    .mem_dat_o (mem_dat_o),
    .read_data (read_data),
    .func_ack  (func_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ReRAM model
  logic [7:0] mem [0:1023];
  int         en_cnt = 0;
  logic       fa_block = 1'b0;

  always @(posedge clk) begin
    en_cnt <= EN ? en_cnt + 1 : 0;
    if (EN && func_ack && !R_WB) mem[mem_dat_o[29:20]] <= mem_dat_o[7:0];
  end
  assign func_ack  = EN && !fa_block && (en_cnt == (R_WB ? 44 : 0));
  assign read_data = {24'h0, mem[mem_dat_o[29:20]]};

  // Protocol watch: never ack+err together, never two ports in one cycle.
  always @(negedge clk) begin
    if (rst_n && (((ack0_o | err0_o) && (ack1_o | err1_o)) ||
                  (ack0_o && err0_o) || (ack1_o && err1_o))) begin
      n_bad++;
      $display("FAIL pulse_exclusive: ack=%b%b err=%b%b, required at most one", ack1_o, ack0_o, err1_o, err0_o);
    end
  end

  typedef struct {
    bit          rst;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [31:0] d0;
    logic [31:0] d1;
    int          p1;
    bit          k1;
    logic [31:0] rd1;
    int          p2;
    bit          k2;
    logic [31:0] rd2;
    int          lat;
    int          en;
  } vec_t;

  function automatic vec_t mk(bit rst, logic [1:0] req, logic [1:0] we,
                              logic [31:0] d0, logic [31:0] d1,
                              int p1, bit k1, logic [31:0] rd1,
                              int p2, bit k2, logic [31:0] rd2,
                              int lat, int en);
    vec_t v;
    v.rst = rst; v.req = req; v.we = we; v.d0 = d0; v.d1 = d1;
    v.p1 = p1; v.k1 = k1; v.rd1 = rd1; v.p2 = p2; v.k2 = k2; v.rd2 = rd2;
    v.lat = lat; v.en = en;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int          np, lat, en_c, need;
    int          pp [2];
    logic        kk [2];
    logic [31:0] rr [2];
    np = 0; lat = -1; en_c = 0;
    need = int'(v.req[0]) + int'(v.req[1]);
    pp[0] = -1; pp[1] = -1; kk[0] = 1'b0; kk[1] = 1'b0; rr[0] = '0; rr[1] = '0;
    if (v.rst) do_reset();
    we0 = v.we[0]; we1 = v.we[1]; dat0 = v.d0; dat1 = v.d1;
    req0 = v.req[0]; req1 = v.req[1];
    for (int c = 0; c < 300 && np < need; c++) begin
      @(posedge clk); #1;
      if (EN) en_c++;
      if (ack0_o || err0_o) begin
        if (np < 2) begin pp[np] = 0; kk[np] = ack0_o; rr[np] = rdat_o; end
        if (np == 0) lat = c;
        np++;
        req0 = 1'b0;
      end
      if (ack1_o || err1_o) begin
        if (np < 2) begin pp[np] = 1; kk[np] = ack1_o; rr[np] = rdat_o; end
        if (np == 0) lat = c;
        np++;
        req1 = 1'b0;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    chk({nm, ".n_resp"}, np, need);
    chk({nm, ".port1"}, pp[0], v.p1);
    chk({nm, ".kind1"}, {31'b0, kk[0]}, {31'b0, v.k1});
    chk({nm, ".latency"}, lat, v.lat);
    chk({nm, ".en_cycles"}, en_c, v.en);
    if (v.k1 && !v.we[v.p1[0]]) chk({nm, ".rdat1"}, rr[0], v.rd1);
    if (need == 2) begin
      chk({nm, ".port2"}, pp[1], v.p2);
      chk({nm, ".kind2"}, {31'b0, kk[1]}, {31'b0, v.k2});
      if (v.k2 && !v.we[v.p2[0]]) chk({nm, ".rdat2"}, rr[1], v.rd2);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  vec_t tbl [10];

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    rst_n = 1'b1; req0 = 0; req1 = 0; we0 = 0; we1 = 0; dat0 = '0; dat1 = '0;

    //            rst req    we     d0            d1            p1 k1 rd1    p2 k2 rd2    lat en
    tbl[0] = mk(0, 2'b01, 2'b01, 32'h0440_00A5, 32'h0,        0, 1, 32'h0,  0, 0, 32'h0,  1,  1);
    tbl[1] = mk(0, 2'b10, 2'b00, 32'h0,        32'h0440_0000, 1, 1, 32'hA5, 0, 0, 32'h0,  45, 45);
    tbl[2] = mk(0, 2'b10, 2'b00, 32'h0,        32'h0440_0000, 1, 0, 32'h0,  0, 0, 32'h0,  0,  0);
    tbl[3] = mk(0, 2'b01, 2'b00, 32'h0440_0000, 32'h0,       0, 0, 32'h0,  0, 0, 32'h0,  0,  0);
    tbl[4] = mk(1, 2'b11, 2'b11, 32'h0100_0011, 32'h0200_0022, 0, 1, 32'h0, 1, 1, 32'h0,  1,  2);
    tbl[5] = mk(0, 2'b11, 2'b00, 32'h0200_0000, 32'h0100_0000, 0, 1, 32'h22, 1, 1, 32'h11, 45, 90);
    tbl[6] = mk(0, 2'b01, 2'b01, 32'h0300_0033, 32'h0,        0, 1, 32'h0,  0, 0, 32'h0,  1,  1);
    tbl[7] = mk(0, 2'b11, 2'b11, 32'h0400_0044, 32'h0500_0055, 1, 1, 32'h0, 0, 1, 32'h0,  1,  2);
    tbl[8] = mk(0, 2'b10, 2'b00, 32'h0,        32'h0500_0000, 1, 1, 32'h55, 0, 0, 32'h0,  45, 45);
    tbl[9] = mk(0, 2'b11, 2'b01, 32'h0600_0066, 32'h0300_0000, 0, 1, 32'h0, 1, 1, 32'h33, 1,  46);

    // Reset values, observed while reset is held.
    #2 rst_n = 1'b0;
    #1;
    chk("rst.EN", EN, 0);
    chk("rst.R_WB", R_WB, 0);
    chk("rst.mem_dat", mem_dat_o, 0);
    chk("rst.rdat", rdat_o, 0);
    chk("rst.pulses", {ack1_o, ack0_o, err1_o, err0_o}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

    // rdat_o must survive a write.
    run_vec(mk(0, 2'b01, 2'b01, 32'h0700_0077, 32'h0, 0, 1, 32'h0, 0, 0, 32'h0, 1, 1), "hold.wr");
    chk("hold.rdat", rdat_o, 32'h33);

    // Fill to DEPTH, then overflow attempts.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      logic [9:0] a;
      a = i[9:0];
      run_vec(mk(0, 2'b01, 2'b01, {2'b00, a, 12'h000, a[7:0]}, 32'h0, 0, 1, 32'h0, 0, 0, 32'h0, 1, 1),
              $sformatf("full.w%0d", i));
    end
    run_vec(mk(0, 2'b01, 2'b01, 32'h0210_00EE, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0), "full.w32");
    run_vec(mk(0, 2'b10, 2'b11, 32'h0, 32'h0220_00EE, 1, 0, 32'h0, 0, 0, 32'h0, 0, 0), "full.w33");
    run_vec(mk(0, 2'b10, 2'b00, 32'h0, 32'h0050_0000, 1, 1, 32'h05, 0, 0, 32'h0, 45, 45), "full.rd");
    run_vec(mk(0, 2'b01, 2'b01, 32'h0230_00DD, 32'h0, 0, 1, 32'h0, 0, 0, 32'h0, 1, 1), "full.wr_again");

`ifdef RERAM_SCHED_TIMEOUT_EN
    do_reset();
    run_vec(mk(0, 2'b01, 2'b01, 32'h0240_00CC, 32'h0, 0, 1, 32'h0, 0, 0, 32'h0, 1, 1), "to.wr");
    fa_block = 1'b1;
    run_vec(mk(0, 2'b10, 2'b00, 32'h0, 32'h0240_0000, 1, 0, 32'h0, 0, 0, 32'h0, 64, 64), "to.rd");
    chk("to.EN_after", EN, 0);
    fa_block = 1'b0;
    // Counter unchanged by the timeout: the single write is still readable.
    run_vec(mk(0, 2'b10, 2'b00, 32'h0, 32'h0240_0000, 1, 1, 32'hCC, 0, 0, 32'h0, 45, 45), "to.rd2");
`endif

    // Reset in the middle of a read.
    do_reset();
    run_vec(mk(0, 2'b01, 2'b01, 32'h0800_0088, 32'h0, 0, 1, 32'h0, 0, 0, 32'h0, 1, 1), "mid.w0");
    run_vec(mk(0, 2'b01, 2'b01, 32'h0900_0099, 32'h0, 0, 1, 32'h0, 0, 0, 32'h0, 1, 1), "mid.w1");
    run_vec(mk(0, 2'b10, 2'b00, 32'h0, 32'h0800_0000, 1, 1, 32'h88, 0, 0, 32'h0, 45, 45), "mid.r0");
    we1 = 1'b0; dat1 = 32'h0900_0000; req1 = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("mid.EN_busy", EN, 1);
    chk("mid.R_WB_busy", R_WB, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("mid.EN", EN, 0);
    chk("mid.R_WB", R_WB, 0);
    chk("mid.mem_dat", mem_dat_o, 0);
    chk("mid.rdat", rdat_o, 0);
    chk("mid.pulses", {ack1_o, ack0_o, err1_o, err0_o}, 0);
    req1 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen;
      seen = 0;
      repeat (5) begin
        @(posedge clk); #1;
        if (ack0_o | ack1_o | err0_o | err1_o | EN) seen++;
      end
      chk("mid.quiet_after", seen, 0);
    end
    run_vec(mk(0, 2'b11, 2'b11, 32'h0A00_00AA, 32'h0B00_00BB, 0, 1, 32'h0, 1, 1, 32'h0, 1, 2), "mid.after");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Hard stop in case something wedges outside the bounded loops.
  initial begin
    #400000;
    $display("FAIL global_timeout: bench still running, required completion");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/reram_req_sched.md
RERAM_REQ_SCHED -- requirements
Module: reram_req_sched

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 64, meaning max cycles EN held without func_ack.
REQ-002 SHALL have parameter DEPTH, default 32, meaning max unread writes the ReRAM model accepts.
REQ-003 SHALL have port wb_clk_i  in  1  the single clock.
REQ-004 SHALL have port wb_rst_i  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports req0_i/req1_i  in  1  requester n transaction request, held until ack or err.
REQ-006 SHALL have ports we0_i/we1_i  in  1  requester n 1=write, 0=read.
REQ-007 SHALL have ports dat0_i/dat1_i  in  32  requester n write word (addr [29:20], data [7:0]).
REQ-008 SHALL have ports ack0_o/ack1_o  out  1  one-cycle completion pulse to requester n.
REQ-009 SHALL have ports err0_o/err1_o  out  1  one-cycle rejection/timeout pulse to requester n.
REQ-010 SHALL have port rdat_o  out  32  read data, valid with ackn_o of a read.
REQ-011 SHALL have ports EN  out  1, R_WB  out  1, mem_dat_o  out  32  drive the ReRAM model.
REQ-012 SHALL have ports read_data  in  32, func_ack  in  1  from the ReRAM model.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-014 IDLE: with any req pending SHALL grant one port round-robin, latch we/dat, go BUSY; EN rises the next cycle.
REQ-015 Round-robin SHALL favour the port not granted last; after reset port 0 has priority; simultaneous req0/req1 resolved by pointer.
REQ-016 BUSY SHALL hold EN=1, R_WB=~we, mem_dat_o=latched data constant until func_ack=1 or timeout; EN never drops early otherwise.
REQ-017 On func_ack in BUSY SHALL drop EN the next cycle, capture read_data into rdat_o (reads only), go RESP.
REQ-018 RESP SHALL pulse ackn_o for exactly one cycle to the granted port, flip the priority pointer, return to IDLE.
REQ-019 Minimum turnaround SHALL be one IDLE cycle between consecutive EN assertions.
REQ-020 Occupancy counter (0..DEPTH) SHALL increment on acked write and decrement on acked read.
REQ-021 Write request with occupancy==DEPTH SHALL be rejected in IDLE: errn_o pulse next cycle, EN not asserted, counter unchanged.
REQ-022 Read request with occupancy==0 SHALL be rejected identically.
REQ-023 Rejected port SHALL still flip the priority pointer.
REQ-024 ackn_o and errn_o SHALL never both be high; at most one port pulses per cycle.
REQ-025 rdat_o SHALL hold its value until the next completed read.
REQ-026 Request deasserted by a requester before ack SHALL not abort an issued transaction; result discarded if req low in RESP.

Reset
REQ-027 wb_rst_i low SHALL asynchronously force IDLE, EN=0, R_WB=0, mem_dat_o=0, rdat_o=0, all ack/err=0, occupancy=0, pointer=port 0.
REQ-028 Reset during BUSY SHALL abandon the transaction with no ack/err issued.

Configuration
REQ-029 With RERAM_SCHED_TIMEOUT_EN defined, a cycle counter SHALL run in BUSY; at TIMEOUT_CYC cycles without func_ack, EN drops, errn_o pulses, occupancy unchanged, FSM returns to IDLE.
REQ-030 Without RERAM_SCHED_TIMEOUT_EN, no counter SHALL exist and BUSY waits indefinitely for func_ack.

Structure
REQ-031 Package reram_sched_pkg SHALL hold the FSM state enum, DEPTH default and port-index typedef.
REQ-032 Round-robin grant logic SHALL be sub-module reram_rr_arbiter (2 requests, pointer in, one-hot grant out).

Verification
REQ-033 req0 write dat0=0x0440_00A5, model acks next cycle -> EN high 1 cycle-window, ack0_o one pulse, occupancy=1.
REQ-034 After REQ-033, req1 read -> EN held ~45 cycles (RD_Dly 44), rdat_o=0x0000_00A5 with ack1_o, occupancy=0.
REQ-035 req0 and req1 writes asserted same cycle after reset -> port 0 served first, port 1 next, alternating under continuous load.
REQ-036 33 writes without reads -> first 32 ack, 33rd gets err pulse, EN not asserted for it.
REQ-037 Read at occupancy 0 -> err pulse, no EN; with RERAM_SCHED_TIMEOUT_EN and func_ack tied low -> err after 64 cycles, EN low after.
REQ-038 wb_rst_i low mid-read -> all outputs 0 immediately, no ack, next request served from port 0.
